// File: rtl/sub32_pipe.sv
// Two-stage pipelined subtractor/comparator: diff = a + ~b + 1, split into low and high halves
// across the two stages, with valid/ready handshakes and full backpressure on both sides.

module sub32_half_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
endmodule

module sub32_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);
  localparam int HALF = WIDTH / 2;

  typedef struct packed {
    logic [HALF-1:0] lo;
    logic            c;
    logic [HALF-1:0] ah;
    logic [HALF-1:0] bh;
    logic            sa;
    logic            sb;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;
    logic             neg;
    logic             ovf;
  } res_t;

  logic            s1_valid_q, s1_valid_d;
  logic            out_valid_q, out_valid_d;
  s1_t             s1_q, s1_d;
  res_t            res_q, res_d;
  logic            adv1, adv2, in_ready_c;

  logic [HALF-1:0] b_lo_n;
  logic [HALF-1:0] lo_sum, hi_sum;
  logic            lo_c, hi_c;

  assign b_lo_n = ~b[HALF-1:0];

  // +1 of the two's-complement negate enters as the low-half carry-in
  sub32_half_add #(.W(HALF)) u_lo (
    .x    (a[HALF-1:0]),
    .y    (b_lo_n),
    .cin  (1'b1),
    .sum  (lo_sum),
    .cout (lo_c)
  );

  sub32_half_add #(.W(HALF)) u_hi (
    .x    (s1_q.ah),
    .y    (s1_q.bh),
    .cin  (s1_q.c),
    .sum  (hi_sum),
    .cout (hi_c)
  );

  always_comb begin
    adv2        = s1_valid_q && (!out_valid_q || out_ready);
    in_ready_c  = !s1_valid_q || adv2;
    adv1        = in_valid && in_ready_c;
    s1_valid_d  = adv1 | (s1_valid_q & ~adv2);
    out_valid_d = adv2 | (out_valid_q & ~out_ready);

    s1_d = s1_q;
    if (adv1) begin
      s1_d.lo = lo_sum;
      s1_d.c  = lo_c;
      s1_d.ah = a[WIDTH-1:HALF];
      s1_d.bh = ~b[WIDTH-1:HALF];
      s1_d.sa = a[WIDTH-1];
      s1_d.sb = b[WIDTH-1];
    end

    res_d = res_q;
    if (adv2) begin
      res_d.diff   = {hi_sum, s1_q.lo};
      res_d.borrow = ~hi_c;
      res_d.zero   = ({hi_sum, s1_q.lo} == '0);
      res_d.neg    = hi_sum[HALF-1];
      res_d.ovf    = (s1_q.sa != s1_q.sb) && (hi_sum[HALF-1] != s1_q.sa);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_q        <= '0;
      res_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      s1_q        <= s1_d;
      res_q       <= res_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign diff      = res_q.diff;
  assign borrow    = res_q.borrow;
  assign zero      = res_q.zero;
  assign neg       = res_q.neg;
  assign ovf       = res_q.ovf;

endmodule
